cache_line_fill: RTL and testbench

Miss-refill engine between the set-associative cache (512 sets, 8 ways, 4 x 64-bit words per line) and main memory. It accepts one miss request from the cache and issues the line's four word reads to memory. It reassembles the returned words into a 256-bit line and hands the line, with its tag and set, back to the cache for install. With critical-word-first enabled, it also forwards the requested word early.

---
 rtl/cache_pkg.sv | 39 +++
 rtl/fill_line_buffer.sv | 31 +++
 rtl/cache_line_fill.sv | 157 +++++++++++++++
 tb/tb_cache_line_fill.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths, address field layout, line type and fill FSM encoding for
// the cache miss-refill engine cache_line_fill.
package cache_pkg;

  localparam int ADDR_W          = 32;
  localparam int WORD_W          = 64;
  localparam int WORDS_PER_LINE  = 4;
  localparam int SET_BITS        = 9;
  localparam int MAX_OUTSTANDING = 4;
  localparam int TAG_BITS        = ADDR_W - 14;

  localparam int BYTE_OFF  = 3;
  localparam int BLOCK_LSB = 3;
  localparam int SET_LSB   = 5;
  localparam int TAG_LSB   = 14;

  localparam int BLK_BITS = $clog2(WORDS_PER_LINE);
  localparam int LINE_W   = WORD_W * WORDS_PER_LINE;
  localparam int CNT_W    = $clog2(WORDS_PER_LINE) + 1;
  localparam int OUT_W    = $clog2(MAX_OUTSTANDING) + 1;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2
  } fill_state_e;

  function automatic logic [ADDR_W-1:0] make_addr(
    input logic [TAG_BITS-1:0] tag_f,
    input logic [SET_BITS-1:0] set_f,
    input logic [BLK_BITS-1:0] blk_f
  );
    return {tag_f, set_f, blk_f, {BYTE_OFF{1'b0}}};
  endfunction

endpackage

// File: rtl/fill_line_buffer.sv
// Line assembly register for cache_line_fill: each returned word lands in
// its own slot of the line, which is cleared only by reset.
module fill_line_buffer
  import cache_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                i_wr_en,
  input  logic [BLK_BITS-1:0] i_wr_slot,
  input  word_t               i_wr_data,
  output line_t               o_line
);

  line_t r_line;

  // write the addressed word slot, all other slots hold
  always_ff @(posedge clock) begin
    if (reset) begin
      r_line <= '0;
    end else begin
      for (int j = 0; j < WORDS_PER_LINE; j++) begin
        if (i_wr_en && (i_wr_slot == BLK_BITS'(j))) begin
          r_line[j*WORD_W +: WORD_W] <= i_wr_data;
        end
      end
    end
  end

  assign o_line = r_line;

endmodule

// File: rtl/cache_line_fill.sv
// Cache miss-refill engine: fetches the four words of a missing line, rebuilds
// the line and hands it back for install. Optional macro
// CACHE_CRITICAL_WORD_FIRST_EN fetches the requested word first and forwards it.
module cache_line_fill
  import cache_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                miss_valid,
  output logic                miss_ready,
  input  logic [ADDR_W-1:0]   miss_addr,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  input  logic                mem_resp_valid,
  input  logic [WORD_W-1:0]   mem_resp_data,
  output logic                crit_valid,
  output logic [WORD_W-1:0]   crit_data,
  output logic                fill_valid,
  input  logic                fill_ready,
  output logic [LINE_W-1:0]   fill_line,
  output logic [TAG_BITS-1:0] fill_tag,
  output logic [SET_BITS-1:0] fill_set
);

  fill_state_e         r_state;
  logic [TAG_BITS-1:0] r_tag;
  logic [SET_BITS-1:0] r_set;
  logic [BLK_BITS-1:0] r_start;
  logic [CNT_W-1:0]    r_req_cnt;
  logic [CNT_W-1:0]    r_resp_cnt;
  logic [OUT_W-1:0]    r_outstanding;
  logic                r_fill_valid;

  logic                w_miss_fire;
  logic                w_req_fire;
  logic                w_resp_fire;
  logic                w_first_resp;
  logic                w_last_resp;
  logic [BLK_BITS-1:0] w_start;
  logic [BLK_BITS-1:0] w_req_blk;
  logic [BLK_BITS-1:0] w_resp_blk;
  line_t               w_line;
  logic                w_unused_addr;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  assign w_start = miss_addr[BLOCK_LSB +: BLK_BITS];
`else
  assign w_start = '0;
`endif
  assign w_unused_addr = &{1'b0, miss_addr[BLOCK_LSB+BLK_BITS-1:0]};

  assign miss_ready    = (r_state == IDLE);
  assign w_miss_fire   = miss_valid && miss_ready;
  // block order wraps inside the line because the sum is only BLK_BITS wide
  assign w_req_blk     = r_start + r_req_cnt[BLK_BITS-1:0];
  assign w_resp_blk    = r_start + r_resp_cnt[BLK_BITS-1:0];
  assign mem_req_valid = (r_state == FETCH) &&
                         (r_req_cnt < CNT_W'(WORDS_PER_LINE)) &&
                         (r_outstanding < OUT_W'(MAX_OUTSTANDING));
  assign mem_req_addr  = make_addr(r_tag, r_set, w_req_blk);
  assign w_req_fire    = mem_req_valid && mem_req_ready;
  // responses with nothing in flight (e.g. after reset) are stale and dropped
  assign w_resp_fire   = mem_resp_valid && (r_state == FETCH) && (r_outstanding != '0);
  assign w_first_resp  = w_resp_fire && (r_resp_cnt == '0);
  assign w_last_resp   = w_resp_fire && (r_resp_cnt == CNT_W'(WORDS_PER_LINE - 1));

  // fill sequencing, request/response bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_tag         <= '0;
      r_set         <= '0;
      r_start       <= '0;
      r_req_cnt     <= '0;
      r_resp_cnt    <= '0;
      r_outstanding <= '0;
      r_fill_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss_fire) begin
            r_state       <= FETCH;
            r_tag         <= miss_addr[TAG_LSB +: TAG_BITS];
            r_set         <= miss_addr[SET_LSB +: SET_BITS];
            r_start       <= w_start;
            r_req_cnt     <= '0;
            r_resp_cnt    <= '0;
            r_outstanding <= '0;
          end
        end
        FETCH: begin
          if (w_req_fire) r_req_cnt <= r_req_cnt + CNT_W'(1);
          if (w_resp_fire) r_resp_cnt <= r_resp_cnt + CNT_W'(1);
          case ({w_req_fire, w_resp_fire})
            2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
            2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
            default: r_outstanding <= r_outstanding;
          endcase
          if (w_last_resp) begin
            r_state      <= DELIVER;
            r_fill_valid <= 1'b1;
          end
        end
        DELIVER: begin
          if (fill_ready) begin
            r_state      <= IDLE;
            r_fill_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_fill_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  logic  r_crit_valid;
  word_t r_crit_data;

  // forward the first returned word one cycle after capture
  always_ff @(posedge clock) begin
    if (reset) begin
      r_crit_valid <= 1'b0;
      r_crit_data  <= '0;
    end else begin
      r_crit_valid <= w_first_resp;
      if (w_first_resp) r_crit_data <= mem_resp_data;
    end
  end

  assign crit_valid = r_crit_valid;
  assign crit_data  = r_crit_data;
`else
  logic w_unused_first;
  assign w_unused_first = w_first_resp;
  assign crit_valid     = 1'b0;
  assign crit_data      = '0;
`endif

  fill_line_buffer u_buf (
    .clock     (clock),
    .reset     (reset),
    .i_wr_en   (w_resp_fire),
    .i_wr_slot (w_resp_blk),
    .i_wr_data (mem_resp_data),
    .o_line    (w_line)
  );

  assign fill_valid = r_fill_valid;
  assign fill_line  = w_line;
  assign fill_tag   = r_tag;
  assign fill_set   = r_set;

endmodule

// File: tb/tb_cache_line_fill.sv
// Self-checking bench for cache_line_fill: in-order memory responder with
// random stalls/latency and a line-level reference model.
`timescale 1ns/1ps
module tb_cache_line_fill;
  import cache_pkg::*;

  logic                clock = 1'b0;
  logic                reset;
  logic                miss_valid;
  logic                miss_ready;
  logic [ADDR_W-1:0]   miss_addr;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic                mem_resp_valid;
  logic [WORD_W-1:0]   mem_resp_data;
  logic                crit_valid;
  logic [WORD_W-1:0]   crit_data;
  logic                fill_valid;
  logic                fill_ready;
  logic [LINE_W-1:0]   fill_line;
  logic [TAG_BITS-1:0] fill_tag;
  logic [SET_BITS-1:0] fill_set;

  cache_line_fill dut (
    .clock(clock), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .crit_valid(crit_valid), .crit_data(crit_data),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_line(fill_line),
    .fill_tag(fill_tag), .fill_set(fill_set)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // memory model controls
  int          ready_mode;   // 0 always ready, 1 random, 2 never
  int          stall_left;
  int          lat_rand;
  bit          resp_rand;
  bit          mem_hold;
  logic [31:0] epoch;

  typedef struct { logic [63:0] data; int due; } pend_t;
  pend_t       pend_q[$];
  logic [31:0] obs_reqs[$];

  // observations of one fill
  int          obs_crit_cnt, obs_unstable, obs_ready_bad, obs_accept_wait;
  bit          obs_timeout, obs_fill_seen;
  logic [63:0] obs_crit_data;
  line_t       obs_line;
  logic [17:0] obs_tag;
  logic [8:0]  obs_set;

  // reference expectations
  logic [31:0] exp_reqs[4];
  line_t       exp_line;
  int          exp_crit_cnt;
  logic [63:0] exp_crit_data;
  logic [17:0] exp_tag;
  logic [8:0]  exp_set;

  function automatic logic [63:0] mem_word(input logic [31:0] a, input logic [31:0] ep);
    return {ep, 3'b000, a[31:3]};
  endfunction

  task automatic model_fill(input logic [31:0] a, input logic [31:0] ep);
    int st;
    logic [31:0] base;
    base = {a[31:5], 5'b00000};
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    st = int'(a[4:3]);
    exp_crit_cnt = 1;
`else
    st = 0;
    exp_crit_cnt = 0;
`endif
    for (int i = 0; i < 4; i++) exp_reqs[i] = base + 32'(((st + i) % 4) * 8);
    for (int j = 0; j < 4; j++) exp_line[j*64 +: 64] = mem_word(base + 32'(j * 8), ep);
    exp_crit_data = (exp_crit_cnt == 1) ? mem_word(base + 32'(st * 8), ep) : 64'd0;
    exp_tag = a[31:14];
    exp_set = a[13:5];
  endtask

  task automatic mem_drive();
    if (pend_q.size() > 0 && !mem_hold && pend_q[0].due <= cyc &&
        (!resp_rand || $urandom_range(0, 2) != 0)) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = pend_q[0].data;
      pend_q.delete(0);
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = {$urandom, $urandom};
    end
    if (stall_left > 0) begin
      mem_req_ready = 1'b0;
      stall_left--;
    end else begin
      case (ready_mode)
        0:       mem_req_ready = 1'b1;
        1:       mem_req_ready = 1'($urandom_range(0, 1));
        default: mem_req_ready = 1'b0;
      endcase
    end
    if (mem_req_valid && mem_req_ready) begin
      obs_reqs.push_back(mem_req_addr);
      pend_q.push_back('{data: mem_word(mem_req_addr, epoch),
                         due: cyc + 1 + int'($urandom_range(0, lat_rand))});
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic run_fill(input logic [31:0] a, input int fill_delay,
                          input bit hold_en, input logic [31:0] hold_addr);
    int n;
    int wait_cnt;
    bit done;
    obs_reqs.delete();
    obs_crit_cnt = 0; obs_crit_data = '0; obs_unstable = 0; obs_ready_bad = 0;
    obs_timeout = 1'b0; obs_fill_seen = 1'b0; obs_line = '0; obs_tag = '0; obs_set = '0;
    n = 0;
    while (!miss_ready && n < 100) begin
      mem_drive(); step(); n++;
    end
    obs_accept_wait = n;
    if (!miss_ready) begin
      obs_timeout = 1'b1;
      return;
    end
    miss_valid = 1'b1; miss_addr = a;
    mem_drive(); step();
    miss_valid = hold_en; miss_addr = hold_en ? hold_addr : 32'd0;
    done = 1'b0; wait_cnt = 0; n = 0;
    while (!done && n < 400) begin
      if (miss_ready) obs_ready_bad++;
      if (crit_valid) begin
        obs_crit_cnt++;
        obs_crit_data = crit_data;
      end
      if (fill_valid) begin
        if (!obs_fill_seen) begin
          obs_fill_seen = 1'b1;
          obs_line = fill_line; obs_tag = fill_tag; obs_set = fill_set;
        end else if (fill_line !== obs_line || fill_tag !== obs_tag || fill_set !== obs_set) begin
          obs_unstable++;
        end
        if (wait_cnt >= fill_delay) begin
          fill_ready = 1'b1;
          done = 1'b1;
        end else begin
          fill_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        if (obs_fill_seen) obs_unstable++;
        fill_ready = 1'($urandom_range(0, 1));
      end
      mem_drive(); step(); n++;
    end
    fill_ready = 1'b0;
    if (!done) obs_timeout = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL reset_miss_ready got %b want 1", miss_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'd0) begin errors++; $display("FAIL reset_req_addr got %h want 0", mem_req_addr); end
    checks++; if (crit_valid !== 1'b0 || crit_data !== 64'd0) begin errors++; $display("FAIL reset_crit got %b/%h want 0/0", crit_valid, crit_data); end
    checks++; if (fill_valid !== 1'b0 || fill_line !== '0) begin errors++; $display("FAIL reset_fill got %b/%h want 0/0", fill_valid, fill_line); end
    checks++; if (fill_tag !== 18'd0 || fill_set !== 9'd0) begin errors++; $display("FAIL reset_tag_set got %h/%h want 0/0", fill_tag, fill_set); end
  endtask

  task automatic test_critical_word();
    logic [31:0] want[4];
    logic [63:0] want_crit;
    int want_cnt;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    want = '{32'd65688, 32'd65664, 32'd65672, 32'd65680};
    want_crit = 64'd8211; want_cnt = 1;
`else
    want = '{32'd65664, 32'd65672, 32'd65680, 32'd65688};
    want_crit = 64'd0; want_cnt = 0;
`endif
    epoch = 32'd0; ready_mode = 0; lat_rand = 0; resp_rand = 1'b0;
    run_fill(make_addr(18'd4, 9'd4, 2'd3), 0, 1'b0, 32'd0);
    checks++; if (obs_timeout || obs_reqs.size() != 4) begin errors++; $display("FAIL cwf_req_count got %0d (timeout %b) want 4", obs_reqs.size(), obs_timeout); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= obs_reqs.size() || obs_reqs[i] !== want[i]) begin
        errors++; $display("FAIL cwf_req_addr[%0d] got %0d want %0d", i, (i < obs_reqs.size()) ? obs_reqs[i] : 32'd0, want[i]);
      end
    end
    checks++; if (obs_crit_cnt != want_cnt || obs_crit_data !== want_crit) begin errors++; $display("FAIL cwf_crit got %0d pulses data %0d want %0d pulses data %0d", obs_crit_cnt, obs_crit_data, want_cnt, want_crit); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (obs_line[j*64 +: 64] !== 64'(8208 + j)) begin errors++; $display("FAIL cwf_line_word[%0d] got %0d want %0d", j, obs_line[j*64 +: 64], 8208 + j); end
    end
    checks++; if (obs_tag !== 18'd4 || obs_set !== 9'd4) begin errors++; $display("FAIL cwf_tag_set got %0d/%0d want 4/4", obs_tag, obs_set); end
  endtask

  task automatic test_stall();
    logic [31:0] a;
    a = $urandom;
    epoch = 32'd1; ready_mode = 1; lat_rand = 3; resp_rand = 1'b1; stall_left = 5;
    model_fill(a, epoch);
    run_fill(a, 0, 1'b0, 32'd0);
    checks++; if (obs_timeout || obs_reqs.size() != 4) begin errors++; $display("FAIL stall_req_count got %0d (timeout %b) want 4", obs_reqs.size(), obs_timeout); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= obs_reqs.size() || obs_reqs[i] !== exp_reqs[i]) begin errors++; $display("FAIL stall_req_addr[%0d] got %h want %h", i, (i < obs_reqs.size()) ? obs_reqs[i] : 32'd0, exp_reqs[i]); end
    end
    checks++; if (obs_line !== exp_line) begin errors++; $display("FAIL stall_line got %h want %h", obs_line, exp_line); end
    checks++; if (obs_crit_cnt != exp_crit_cnt || obs_crit_data !== exp_crit_data) begin errors++; $display("FAIL stall_crit got %0d/%h want %0d/%h", obs_crit_cnt, obs_crit_data, exp_crit_cnt, exp_crit_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, a2;
    a1 = $urandom;
    a2 = make_addr(18'd7, 9'd511, 2'd0);
    epoch = 32'd4; ready_mode = 0; lat_rand = 1; resp_rand = 1'b0;
    model_fill(a1, epoch);
    run_fill(a1, 10, 1'b1, a2);
    checks++; if (obs_timeout || obs_unstable != 0) begin errors++; $display("FAIL b2b_hold_stable got %0d changes (timeout %b) want 0", obs_unstable, obs_timeout); end
    checks++; if (obs_ready_bad != 0) begin errors++; $display("FAIL b2b_miss_ready_busy got %0d ready cycles want 0", obs_ready_bad); end
    checks++; if (obs_line !== exp_line || obs_tag !== exp_tag || obs_set !== exp_set) begin errors++; $display("FAIL b2b_first_line got %h/%h/%h want %h/%h/%h", obs_line, obs_tag, obs_set, exp_line, exp_tag, exp_set); end
    model_fill(a2, epoch);
    run_fill(a2, 0, 1'b0, 32'd0);
    checks++; if (obs_accept_wait != 0) begin errors++; $display("FAIL b2b_second_accept got wait %0d want 0", obs_accept_wait); end
    checks++; if (obs_timeout || obs_line !== exp_line || obs_tag !== 18'd7 || obs_set !== 9'd511) begin errors++; $display("FAIL b2b_second_line got %h/%h/%h want %h/7/511", obs_line, obs_tag, obs_set, exp_line); end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] a;
    int n;
    int bad;
    epoch = 32'd2; ready_mode = 0; lat_rand = 0; resp_rand = 1'b0; mem_hold = 1'b1;
    obs_reqs.delete();
    miss_valid = 1'b1; miss_addr = $urandom;
    mem_drive(); step();
    miss_valid = 1'b0;
    n = 0;
    while (obs_reqs.size() < 2 && n < 20) begin
      mem_drive(); step(); n++;
    end
    checks++; if (obs_reqs.size() != 2) begin errors++; $display("FAIL rst_mid_two_reqs got %0d want 2", obs_reqs.size()); end
    reset = 1'b1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    step();
    reset = 1'b0;
    checks++; if (mem_req_valid !== 1'b0 || fill_valid !== 1'b0 || miss_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_idle got req %b fill %b ready %b want 0/0/1", mem_req_valid, fill_valid, miss_ready); end
    mem_hold = 1'b0; ready_mode = 2; bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (fill_valid || crit_valid || mem_req_valid) bad++;
      mem_drive(); step();
    end
    checks++; if (bad != 0 || pend_q.size() != 0) begin errors++; $display("FAIL rst_mid_stale_drop got %0d bad cycles, %0d undelivered want 0/0", bad, pend_q.size()); end
    a = $urandom;
    epoch = 32'd3; ready_mode = 1; lat_rand = 2;
    model_fill(a, epoch);
    run_fill(a, 1, 1'b0, 32'd0);
    checks++; if (obs_timeout || obs_line !== exp_line || obs_crit_data !== exp_crit_data) begin errors++; $display("FAIL rst_mid_fresh_fill got %h/%h want %h/%h", obs_line, obs_crit_data, exp_line, exp_crit_data); end
  endtask

  task automatic test_boundary();
    logic [31:0] want[4];
    want = '{32'hFFFF_FFE0, 32'hFFFF_FFE8, 32'hFFFF_FFF0, 32'hFFFF_FFF8};
    epoch = 32'd5; ready_mode = 0; lat_rand = 0; resp_rand = 1'b0;
    model_fill(make_addr(18'h3FFFF, 9'd511, 2'd0), epoch);
    run_fill(make_addr(18'h3FFFF, 9'd511, 2'd0), 0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= obs_reqs.size() || obs_reqs[i] !== want[i]) begin errors++; $display("FAIL bound_req_addr[%0d] got %h want %h", i, (i < obs_reqs.size()) ? obs_reqs[i] : 32'd0, want[i]); end
    end
    checks++; if (obs_set !== 9'd511 || obs_tag !== 18'h3FFFF || obs_line !== exp_line) begin errors++; $display("FAIL bound_fill got set %0d tag %h want 511/3ffff", obs_set, obs_tag); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int t = 0; t < 20; t++) begin
      a = $urandom;
      epoch = 32'(100 + t);
      ready_mode = int'($urandom_range(0, 1));
      lat_rand = int'($urandom_range(0, 6));
      resp_rand = 1'($urandom_range(0, 1));
      stall_left = int'($urandom_range(0, 3));
      model_fill(a, epoch);
      run_fill(a, int'($urandom_range(0, 3)), 1'b0, 32'd0);
      checks++;
      if (obs_timeout || obs_reqs.size() != 4) begin errors++; $display("FAIL rand%0d_req_count got %0d (timeout %b) want 4", t, obs_reqs.size(), obs_timeout); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (i >= obs_reqs.size() || obs_reqs[i] !== exp_reqs[i]) begin errors++; $display("FAIL rand%0d_req_addr[%0d] got %h want %h", t, i, (i < obs_reqs.size()) ? obs_reqs[i] : 32'd0, exp_reqs[i]); end
      end
      checks++;
      if (obs_line !== exp_line || obs_tag !== exp_tag || obs_set !== exp_set || obs_unstable != 0) begin errors++; $display("FAIL rand%0d_fill got %h/%h/%h want %h/%h/%h", t, obs_line, obs_tag, obs_set, exp_line, exp_tag, exp_set); end
      checks++;
      if (obs_crit_cnt != exp_crit_cnt || obs_crit_data !== exp_crit_data) begin errors++; $display("FAIL rand%0d_crit got %0d/%h want %0d/%h", t, obs_crit_cnt, obs_crit_data, exp_crit_cnt, exp_crit_data); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; miss_valid = 1'b0; miss_addr = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0; fill_ready = 1'b0;
    ready_mode = 0; stall_left = 0; lat_rand = 0; resp_rand = 1'b0; mem_hold = 1'b0; epoch = '0;
    @(negedge clock);
    test_reset();
    test_critical_word();
    test_stall();
    test_back_to_back();
    test_reset_mid_fill();
    test_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
